// File: rtl/vector_alu_exec.sv
// Vector execute stage: latches one op, computes LANES x WIDTH lane results (iterative
// restoring divide for DIV) and holds them until writeback. Option: VEC_ALU_SATURATE_EN.
module vector_alu_exec #(
   parameter int unsigned LANES = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             alu_control,
   input  logic                   src_a_sel,
   input  logic [LANES*WIDTH-1:0] vec_a,
   input  logic [WIDTH-1:0]       scalar_a,
   input  logic [LANES*WIDTH-1:0] vec_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] result,
   output logic [LANES-1:0]       flag_z,
   output logic [LANES-1:0]       flag_n,
   output logic                   div_zero,
   output logic                   write_en
);

   localparam int unsigned VW = LANES * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OpAdd = 3'b000;
   localparam logic [2:0] OpSub = 3'b001;
   localparam logic [2:0] OpMov = 3'b010;
   localparam logic [2:0] OpMul = 3'b011;
   localparam logic [2:0] OpDiv = 3'b100;
   localparam logic [2:0] OpCmp = 3'b101;
   localparam logic [2:0] OpDup = 3'b111;

   typedef enum logic [1:0] {StIdle, StExec, StDiv, StHold} state_e;

   state_e          state_q, state_d;
   logic [2:0]      op_q;
   logic            sel_q;
   logic [VW-1:0]   a_q, b_q, rem_q, quo_q;
   logic [CW-1:0]   cnt_q;
   logic [VW-1:0]   result_q;
   logic [LANES-1:0] flag_z_q, flag_n_q;
   logic            div_zero_q, write_en_q;

   logic [VW-1:0]   a_in;
   logic            div_last;

   // single-cycle datapath
   logic [VW-1:0]    ex_result;
   logic [LANES-1:0] ex_z, ex_n;
   logic             ex_we;
   logic [WIDTH-1:0] la, lb, lr;
   logic [WIDTH:0]   lsum;
   logic [2*WIDTH-1:0] lprod;

   // divide datapath
   logic [VW-1:0]    dv_dvd, dv_rem, dv_quo;
   logic [LANES-1:0] dv_z, dv_bz;
   logic [WIDTH-1:0] da, db, dr, dq;
   logic [WIDTH:0]   dshift, ddiff;
   logic             dge;

   assign a_in     = src_a_sel ? {LANES{scalar_a}} : vec_a;
   assign div_last = (cnt_q == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (in_valid) state_d = (alu_control == OpDiv) ? StDiv : StExec;
         StExec:  state_d = StHold;
         StDiv:   if (div_last) state_d = StHold;
         StHold:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StHold);
      result    = result_q;
      flag_z    = flag_z_q;
      flag_n    = flag_n_q;
      div_zero  = div_zero_q;
      write_en  = write_en_q;
   end

   always_comb begin
      ex_result = '0;
      ex_z      = '0;
      ex_n      = '0;
      la        = '0;
      lb        = '0;
      lr        = '0;
      lsum      = '0;
      lprod     = '0;
      case (op_q)
         OpAdd, OpSub, OpMov, OpMul: ex_we = 1'b1;
         OpDup:                      ex_we = !sel_q;
         default:                    ex_we = 1'b0;
      endcase
      for (int i = 0; i < int'(LANES); i++) begin
         la    = a_q[i*WIDTH +: WIDTH];
         lb    = b_q[i*WIDTH +: WIDTH];
         lsum  = {1'b0, la} + {1'b0, lb};
         lprod = {{WIDTH{1'b0}}, la} * {{WIDTH{1'b0}}, lb};
         case (op_q)
`ifdef VEC_ALU_SATURATE_EN
            OpAdd: lr = lsum[WIDTH] ? '1 : lsum[WIDTH-1:0];
            OpSub: lr = (la < lb) ? '0 : la - lb;
            OpMul: lr = (lprod[2*WIDTH-1:WIDTH] != '0) ? '1 : lprod[WIDTH-1:0];
`else
            OpAdd: lr = lsum[WIDTH-1:0];
            OpSub: lr = la - lb;
            OpMul: lr = lprod[WIDTH-1:0];
`endif
            OpMov: lr = lb;
            OpDup: lr = sel_q ? '0 : a_q[WIDTH-1:0];
            default: lr = '0;
         endcase
         ex_result[i*WIDTH +: WIDTH] = lr;
         ex_z[i] = (op_q == OpCmp) ? (la == lb) : (lr == '0);
         ex_n[i] = (op_q == OpCmp) && (la < lb);
      end
   end

   // One restoring step per lane; a zero divisor always subtracts, giving all-ones quotient.
   always_comb begin
      dv_dvd = '0;
      dv_rem = '0;
      dv_quo = '0;
      dv_z   = '0;
      dv_bz  = '0;
      da     = '0;
      db     = '0;
      dr     = '0;
      dq     = '0;
      dshift = '0;
      ddiff  = '0;
      dge    = 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
         da     = a_q[i*WIDTH +: WIDTH];
         db     = b_q[i*WIDTH +: WIDTH];
         dr     = rem_q[i*WIDTH +: WIDTH];
         dq     = quo_q[i*WIDTH +: WIDTH];
         dshift = {dr, da[WIDTH-1]};
         ddiff  = dshift - {1'b0, db};
         dge    = (dshift >= {1'b0, db});
         dv_rem[i*WIDTH +: WIDTH] = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
         dv_quo[i*WIDTH +: WIDTH] = {dq[WIDTH-2:0], dge};
         dv_dvd[i*WIDTH +: WIDTH] = {da[WIDTH-2:0], 1'b0};
         dv_z[i]  = ({dq[WIDTH-2:0], dge} == '0);
         dv_bz[i] = (db == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         sel_q      <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         flag_z_q   <= '0;
         flag_n_q   <= '0;
         div_zero_q <= 1'b0;
         write_en_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_q  <= alu_control;
                  sel_q <= src_a_sel;
                  a_q   <= a_in;
                  b_q   <= vec_b;
                  rem_q <= '0;
                  quo_q <= '0;
                  cnt_q <= '0;
               end
            end
            StExec: begin
               result_q   <= ex_result;
               flag_z_q   <= ex_z;
               flag_n_q   <= ex_n;
               div_zero_q <= 1'b0;
               write_en_q <= ex_we;
            end
            StDiv: begin
               a_q   <= dv_dvd;
               rem_q <= dv_rem;
               quo_q <= dv_quo;
               cnt_q <= cnt_q + 1'b1;
               if (div_last) begin
                  result_q   <= dv_quo;
                  flag_z_q   <= dv_z;
                  flag_n_q   <= '0;
                  div_zero_q <= |dv_bz;
                  write_en_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_alu_exec.sv
// Directed self-checking bench for vector_alu_exec (LANES=4, WIDTH=8).
module tb_vector_alu_exec;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, src_a_sel, out_valid, out_ready;
   logic [2:0]  alu_control;
   logic [31:0] vec_a, vec_b, result;
   logic [7:0]  scalar_a;
   logic [3:0]  flag_z, flag_n;
   logic        div_zero, write_en;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vector_alu_exec #(.LANES(4), .WIDTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .src_a_sel(src_a_sel), .vec_a(vec_a),
      .scalar_a(scalar_a), .vec_b(vec_b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flag_z(flag_z), .flag_n(flag_n), .div_zero(div_zero),
      .write_en(write_en)
   );

   function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
      return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present an op and consume the accept edge.
   task automatic issue(input logic [2:0] op, input logic sel, input logic [31:0] va,
                        input logic [7:0] sa, input logic [31:0] vb);
      alu_control = op;
      src_a_sel   = sel;
      vec_a       = va;
      scalar_a    = sa;
      vec_b       = vb;
      in_valid    = 1'b1;
      tick();
      in_valid    = 1'b0;
      vec_a       = 32'hdead_beef;
      vec_b       = 32'h1234_5678;
      scalar_a    = 8'h77;
   endtask

   logic [31:0] held;
   logic        seen;

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_control = 3'b000;
      src_a_sel = 1'b0; vec_a = '0; vec_b = '0; scalar_a = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_we", {31'b0, write_en}, 32'd0);

      // ADD with wrap / clamp in lane 0
      issue(3'b000, 1'b0, pk(250, 1, 2, 3), 8'd0, pk(10, 1, 1, 1));
      chk("add_lat1_valid", {31'b0, out_valid}, 32'd0);
      chk("add_lat1_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("add_valid", {31'b0, out_valid}, 32'd1);
`ifdef VEC_ALU_SATURATE_EN
      chk("add_result", result, pk(255, 2, 3, 4));
`else
      chk("add_result", result, pk(4, 2, 3, 4));
`endif
      chk("add_we", {31'b0, write_en}, 32'd1);
      chk("add_fz", {28'b0, flag_z}, 32'd0);
      tick();
      chk("add_done_valid", {31'b0, out_valid}, 32'd0);
      chk("add_done_ready", {31'b0, in_ready}, 32'd1);

      // DIV including divide by zero and zero dividend
      issue(3'b100, 1'b0, pk(200, 7, 9, 0), 8'd0, pk(10, 2, 0, 5));
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      if (out_valid) seen = 1'b1;
      chk("div_early_valid", {31'b0, seen}, 32'd0);
      tick();
      chk("div_valid", {31'b0, out_valid}, 32'd1);
      chk("div_result", result, pk(20, 3, 255, 0));
      chk("div_zero", {31'b0, div_zero}, 32'd1);
      chk("div_fz", {28'b0, flag_z}, 32'b1000);
      chk("div_we", {31'b0, write_en}, 32'd1);
      tick();

      // CMP with broadcast scalar
      issue(3'b101, 1'b1, pk(1, 2, 3, 4), 8'd5, pk(5, 6, 4, 5));
      tick();
      chk("cmp_fz", {28'b0, flag_z}, 32'b1001);
      chk("cmp_fn", {28'b0, flag_n}, 32'b0010);
      chk("cmp_we", {31'b0, write_en}, 32'd0);
      chk("cmp_result", result, 32'd0);
      chk("cmp_div_zero", {31'b0, div_zero}, 32'd0);
      tick();

      // Backpressure: result held, second op not taken until IDLE
      out_ready = 1'b0;
      issue(3'b000, 1'b0, pk(1, 2, 3, 4), 8'd0, pk(1, 1, 1, 1));
      tick();
      held = result;
      alu_control = 3'b010; src_a_sel = 1'b0; vec_b = pk(9, 9, 9, 9); in_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (!out_valid || in_ready || result !== held) seen = 1'b1;
         tick();
      end
      chk("bp_hold_stable", {31'b0, seen}, 32'd0);
      chk("bp_result", result, pk(2, 3, 4, 5));
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", {31'b0, out_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_accept_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk("mov_valid", {31'b0, out_valid}, 32'd1);
      chk("mov_result", result, pk(9, 9, 9, 9));
      tick();

      // Reset during DIV aborts the op
      issue(3'b100, 1'b0, pk(200, 7, 9, 0), 8'd0, pk(10, 2, 0, 5));
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_ready", {31'b0, in_ready}, 32'd1);
      chk("abort_result", result, 32'd0);
      chk("abort_flags", {24'b0, flag_z, flag_n}, 32'd0);
      chk("abort_we_dz", {30'b0, write_en, div_zero}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("abort_no_output", {31'b0, seen}, 32'd0);

      // MUL
      issue(3'b011, 1'b0, pk(16, 3, 0, 255), 8'd0, pk(16, 5, 9, 2));
      tick();
`ifdef VEC_ALU_SATURATE_EN
      chk("mul_result", result, pk(255, 15, 0, 255));
      chk("mul_fz", {28'b0, flag_z}, 32'b0100);
`else
      chk("mul_result", result, pk(0, 15, 0, 254));
      chk("mul_fz", {28'b0, flag_z}, 32'b0101);
`endif
      tick();

      // SUB underflow
      issue(3'b001, 1'b0, pk(5, 0, 100, 7), 8'd0, pk(3, 1, 40, 7));
      tick();
`ifdef VEC_ALU_SATURATE_EN
      chk("sub_result", result, pk(2, 0, 60, 0));
      chk("sub_fz", {28'b0, flag_z}, 32'b1010);
`else
      chk("sub_result", result, pk(2, 255, 60, 0));
      chk("sub_fz", {28'b0, flag_z}, 32'b1000);
`endif
      tick();

      // DUP lane 0 of A, then NOP
      issue(3'b111, 1'b0, pk(7, 1, 2, 3), 8'd0, pk(0, 0, 0, 0));
      tick();
      chk("dup_result", result, pk(7, 7, 7, 7));
      chk("dup_we", {31'b0, write_en}, 32'd1);
      tick();
      issue(3'b111, 1'b1, pk(7, 1, 2, 3), 8'd9, pk(0, 0, 0, 0));
      tick();
      chk("nop_we", {31'b0, write_en}, 32'd0);
      chk("nop_fn", {28'b0, flag_n}, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
